// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// slave = the pipeline itself; master = operand source plus result consumer.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] z;
    logic [CNT_W-1:0] count;

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, z, count
    );

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, z, count
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit feeding STAGES elastic register stages; latency STAGES cycles, one beat/cycle.
// Stalls hold the output while bubbles upstream collapse; in_ready falls only when every stage is full.
module logic_unit_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    logic_unit_pipe_if.slave   bus
);

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] load_ok;
    logic [WIDTH-1:0]  dat_q [STAGES];
    logic [WIDTH-1:0]  dat_d [STAGES];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  res;

    always_comb begin
        res = '0;
        case (bus.op)
            3'd0: res = ~bus.a;
            3'd1: res = bus.a;
            3'd2: res = bus.a & bus.b;
            3'd3: res = bus.a | bus.b;
            3'd4: res = bus.a ^ bus.b;
            3'd5: res = ~(bus.a & bus.b);
            3'd6: res = ~(bus.a | bus.b);
            3'd7: res = ~(bus.a ^ bus.b);
            default: res = '0;
        endcase
    end

    // A stage may load when the consumer takes the head or any slot from here to the tail is empty.
    always_comb begin
        logic tail_full;
        tail_full = 1'b1;
        load_ok   = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            tail_full  = tail_full & vld_q[k];
            load_ok[k] = bus.out_ready | ~tail_full;
        end
    end

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        cnt_d = cnt_q;
        if (load_ok[0]) begin
            vld_d[0] = bus.in_valid;
            if (bus.in_valid) begin
                dat_d[0] = res;
            end
        end
        for (int k = 1; k < STAGES; k++) begin
            if (load_ok[k]) begin
                vld_d[k] = vld_q[k-1];
                if (vld_q[k-1]) begin
                    dat_d[k] = dat_q[k-1];
                end
            end
        end
        if (vld_q[STAGES-1] && bus.out_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cnt_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
            dat_q <= dat_d;
        end
    end

    assign bus.in_ready  = load_ok[0];
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.z         = dat_q[STAGES-1];
    assign bus.count     = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
`timescale 1ns/1ps
// Drives three pipelines (STAGES 2/4/1, CNT_W 16/3/16) from one source and checks them against a queue model.
module tb_logic_unit_pipe;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic [2:0] op = 3'd0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic_unit_pipe_if #(.WIDTH(8), .CNT_W(16)) bus0 ();
    logic_unit_pipe_if #(.WIDTH(8), .CNT_W(3))  bus1 ();
    logic_unit_pipe_if #(.WIDTH(8), .CNT_W(16)) bus2 ();

    assign bus0.in_valid = in_valid;  assign bus0.a = a;  assign bus0.b = b;
    assign bus0.op = op;              assign bus0.out_ready = out_ready;
    assign bus1.in_valid = in_valid;  assign bus1.a = a;  assign bus1.b = b;
    assign bus1.op = op;              assign bus1.out_ready = out_ready;
    assign bus2.in_valid = in_valid;  assign bus2.a = a;  assign bus2.b = b;
    assign bus2.op = op;              assign bus2.out_ready = out_ready;

    logic_unit_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    logic_unit_pipe #(.WIDTH(8), .STAGES(4), .CNT_W(3))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    logic_unit_pipe #(.WIDTH(8), .STAGES(1), .CNT_W(16)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    logic        ir [NI];
    logic        ov [NI];
    logic [7:0]  zz [NI];
    logic [15:0] cc [NI];
    assign ir[0] = bus0.in_ready;  assign ov[0] = bus0.out_valid;
    assign zz[0] = bus0.z;         assign cc[0] = bus0.count;
    assign ir[1] = bus1.in_ready;  assign ov[1] = bus1.out_valid;
    assign zz[1] = bus1.z;         assign cc[1] = {13'd0, bus1.count};
    assign ir[2] = bus2.in_ready;  assign ov[2] = bus2.out_valid;
    assign zz[2] = bus2.z;         assign cc[2] = bus2.count;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h, expected %0h at %0t", nm, idx, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_op(input logic [7:0] x, input logic [7:0] y, input logic [2:0] o);
        case (o)
            3'd0: return ~x;
            3'd1: return x;
            3'd2: return x & y;
            3'd3: return x | y;
            3'd4: return x ^ y;
            3'd5: return ~(x & y);
            3'd6: return ~(x | y);
            default: return ~(x ^ y);
        endcase
    endfunction

    function automatic int stg(input int i);
        return (i == 0) ? 2 : (i == 1) ? 4 : 1;
    endfunction

    function automatic int cmod(input int i);
        return (i == 1) ? 8 : 65536;
    endfunction

    // Model: per instance, an in-order list of in-flight results with the edge index of acceptance.
    // The oldest result moves forward every edge until it reaches the output, so it is
    // visible once its age in edges is at least STAGES-1.
    logic [7:0] md [NI][8];
    int         mt [NI][8];
    int         hd [NI];
    int         nq [NI];
    int         mcnt [NI];
    int         edge_n;
    logic       m_acc, m_dlv;

    function automatic logic exp_vld(input int i);
        return (nq[i] > 0) && ((edge_n - 1 - mt[i][hd[i]]) >= stg(i) - 1);
    endfunction

    function automatic logic exp_rdy(input int i);
        return (nq[i] < stg(i)) || out_ready;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                hd[i] = 0;
                nq[i] = 0;
                mcnt[i] = 0;
            end
            edge_n = 0;
        end else begin
            for (int i = 0; i < NI; i++) begin
                m_acc = in_valid && exp_rdy(i);
                m_dlv = exp_vld(i) && out_ready;
                if (m_dlv) begin
                    hd[i] = (hd[i] + 1) % 8;
                    nq[i] = nq[i] - 1;
                    mcnt[i] = (mcnt[i] + 1) % cmod(i);
                end
                if (m_acc) begin
                    md[i][(hd[i] + nq[i]) % 8] = ref_op(a, b, op);
                    mt[i][(hd[i] + nq[i]) % 8] = edge_n;
                    nq[i] = nq[i] + 1;
                end
            end
            edge_n = edge_n + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NI; i++) begin
                chk("in_ready", i, 32'(ir[i]), 32'(exp_rdy(i)));
                chk("out_valid", i, 32'(ov[i]), 32'(exp_vld(i)));
                if (exp_vld(i)) chk("z", i, 32'(zz[i]), 32'(md[i][hd[i]]));
                chk("count", i, 32'(cc[i]), 32'(mcnt[i]));
            end
        end
    end

    // Delivered-result log of dut0, accept tally of dut0, and dut1 count after each delivery.
    logic [7:0] cap0 [$];
    int         acc0 = 0;
    int         dl1_seen = 0;
    int         dl1_logged = 0;
    int         cnt1_log [$];

    always @(posedge clk) begin
        if (rst_n) begin
            if (bus0.out_valid && bus0.out_ready) cap0.push_back(bus0.z);
            if (bus0.in_valid && bus0.in_ready) acc0++;
            if (bus1.out_valid && bus1.out_ready) dl1_seen++;
        end
    end

    always @(negedge clk) begin
        while (dl1_logged < dl1_seen) begin
            cnt1_log.push_back(int'(bus1.count));
            dl1_logged++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        logic [7:0] lits [8];
        logic [7:0] rq [$];
        int base, abase, j, cyc;
        logic hs;

        // Reset state
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_out_valid", i, 32'(ov[i]), 32'd0);
            chk("rst_z", i, 32'(zz[i]), 32'd0);
            chk("rst_count", i, 32'(cc[i]), 32'd0);
            chk("rst_in_ready", i, 32'(ir[i]), 32'd1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All ops back to back, latency per STAGES
        lits = '{8'h3A, 8'hC5, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
        base = cap0.size();
        a = 8'hC5; b = 8'h3A; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            op = 3'(k);
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("ops_s1_vld", k, 32'(ov[2]), 32'd1);
            chk("ops_s1_z", k, 32'(zz[2]), 32'(lits[k]));
            chk("ops_s2_vld", k, 32'(ov[0]), (k >= 1) ? 32'd1 : 32'd0);
            if (k >= 1) chk("ops_s2_z", k, 32'(zz[0]), 32'(lits[k-1]));
            chk("ops_s4_vld", k, 32'(ov[1]), (k >= 3) ? 32'd1 : 32'd0);
            if (k >= 3) chk("ops_s4_z", k, 32'(zz[1]), 32'(lits[k-3]));
            #1;
        end
        in_valid = 1'b0;
        repeat (5) tick();
        chk("ops_count_s2", 0, 32'(cc[0]), 32'd8);
        chk("ops_count_s4_wrap", 1, 32'(cc[1]), 32'd0);
        chk("ops_count_s1", 2, 32'(cc[2]), 32'd8);
        chk("ops_ndeliv", 0, 32'(cap0.size() - base), 32'd8);
        for (int k = 0; k < 8 && base + k < cap0.size(); k++)
            chk("ops_seq", k, 32'(cap0[base+k]), 32'(lits[k]));

        // Back-pressure
        do_reset();
        base = cap0.size(); abase = acc0;
        out_ready = 1'b0; op = 3'd0; a = 8'd1; in_valid = 1'b1; j = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); hs = in_valid && ir[0];
            tick();
            if (hs) begin j++; if (j < 6) a = 8'(j + 1); else in_valid = 1'b0; end
        end
        chk("bp_accepts", 0, 32'(acc0 - abase), 32'd2);
        chk("bp_in_ready", 0, 32'(ir[0]), 32'd0);
        chk("bp_out_valid", 0, 32'(ov[0]), 32'd1);
        chk("bp_z_hold", 0, 32'(zz[0]), 32'hFE);
        out_ready = 1'b1;
        for (int c = 0; c < 40 && j < 6; c++) begin
            @(negedge clk); hs = in_valid && ir[0];
            tick();
            if (hs) begin j++; if (j < 6) a = 8'(j + 1); else in_valid = 1'b0; end
        end
        in_valid = 1'b0;
        repeat (8) tick();
        chk("bp_count", 0, 32'(cc[0]), 32'd6);
        chk("bp_ndeliv", 0, 32'(cap0.size() - base), 32'd6);
        for (int k = 0; k < 6 && base + k < cap0.size(); k++)
            chk("bp_seq", k, 32'(cap0[base+k]), 32'(8'hFE - 8'(k)));

        // Reset mid-stream, between edges
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
            tick();
        end
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("mid_rst_out_valid", i, 32'(ov[i]), 32'd0);
            chk("mid_rst_z", i, 32'(zz[i]), 32'd0);
            chk("mid_rst_count", i, 32'(cc[i]), 32'd0);
            chk("mid_rst_in_ready", i, 32'(ir[i]), 32'd1);
        end
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (6) tick();
        chk("post_rst_count", 0, 32'(cc[0]), 32'd0);
        chk("post_rst_out_valid", 0, 32'(ov[0]), 32'd0);

        // Counter wrap on the CNT_W=3 instance
        do_reset();
        base = cnt1_log.size();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
            tick();
        end
        in_valid = 1'b0;
        repeat (6) tick();
        chk("wrap_ndeliv", 1, 32'(cnt1_log.size() - base), 32'd9);
        for (int k = 0; k < 9 && base + k < cnt1_log.size(); k++)
            chk("wrap_count", k, 32'(cnt1_log[base+k]), 32'((k + 1) % 8));

        // Random handshake, 1000 beats through dut0
        do_reset();
        base = cap0.size(); abase = acc0; cyc = 0;
        in_valid = 1'b0;
        while ((acc0 - abase) < 1000 && cyc < 20000) begin
            @(negedge clk);
            hs = in_valid && ir[0];
            if (hs) rq.push_back(ref_op(a, b, op));
            tick();
            cyc++;
            if (!in_valid || hs) begin
                in_valid = ((acc0 - abase) < 1000) ? 1'($urandom % 2) : 1'b0;
                a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
            end
            out_ready = 1'($urandom % 2);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();
        chk("rnd_accepts", 0, 32'(acc0 - abase), 32'd1000);
        chk("rnd_count", 0, 32'(cc[0]), 32'(1000 % 65536));
        chk("rnd_ndeliv", 0, 32'(cap0.size() - base), 32'(rq.size()));
        for (int k = 0; k < rq.size() && base + k < cap0.size(); k++)
            chk("rnd_seq", k, 32'(cap0[base+k]), 32'(rq[k]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the single-bit inverter.
- Applies one of eight bitwise operations to WIDTH-bit operands: NOT, pass, AND, OR, XOR, NAND, NOR, XNOR.
- Carries each result through STAGES elastic register stages with a valid/ready handshake on both sides, and keeps a wrap-around count of delivered results.
- Sits between an operand source and any consumer that can apply back-pressure.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- STAGES, 2, number of pipeline register stages (>=1); sets latency.
- CNT_W, 16, width of the delivered-result counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat offered.
- in_ready  output  1  block accepts beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B (ignored by op 0 and op 1).
- op  input  3  operation select, sampled with the beat.
- out_valid  output  1  result beat offered.
- out_ready  input  1  consumer accepts result.
- z  output  WIDTH  result.
- count  output  CNT_W  number of results delivered, mod 2^CNT_W.

Behaviour:
- Op encoding, all bitwise over WIDTH:
  - 0 = ~a
  - 1 = a
  - 2 = a&b
  - 3 = a|b
  - 4 = a^b
  - 5 = ~(a&b)
  - 6 = ~(a|b)
  - 7 = ~(a^b)
- The result is computed combinationally from a, b and op at acceptance and written into stage 0. Later stages only move data.
- Each stage k holds a valid flag v[k] and data d[k]. z = d[STAGES-1]; out_valid = v[STAGES-1].
- Stage k can load when its slot is empty or when it is draining this cycle:
  - Last stage: load_ok = !v[last] || out_ready.
  - Other stages: load_ok[k] = !v[k] || load_ok[k+1].
  - in_ready = load_ok[0]. The combinational ready chain is allowed.
- Per stage k, on each rising edge:
  - If load_ok[k] and stage k-1 is valid (or in_valid for k=0): capture the data and set v[k]=1.
  - Else if load_ok[k]: clear v[k].
  - Else: hold.
- Accept = in_valid && in_ready. Deliver = out_valid && out_ready.
- Latency: a beat accepted at edge N is presented at out_valid after edge N+STAGES-1, i.e. visible in the cycle after the STAGES-th capturing edge, when no stall occurs.
- Throughput: one beat per cycle with out_ready held high.
- Ordering: strict FIFO. No beat is dropped or duplicated under any out_ready pattern.
- Stall: while out_valid=1 and out_ready=0, z and out_valid hold stable. Upstream stages keep filling bubbles. in_ready drops only once every stage is valid.
- Full pipeline with out_ready=1 and in_valid=1: accepts and delivers in the same cycle.
- count: increments by 1 on every deliver edge and wraps from 2^CNT_W-1 to 0. It never changes on accept.
- Values on a, b and op when in_valid=0 have no effect.
- in_valid without handshake: the source must hold in_valid=1 and the beat stable until accepted. The block does not check this.
- Reset: on rst_n low, immediately and independent of clk, all v[k]=0, all d[k]=0, count=0.
  - Outputs during reset: out_valid=0, z=0, count=0.
  - in_ready=1, because the chain is empty.
  - Reset mid-operation discards all in-flight beats.
  - The first accept is possible on the first rising edge after rst_n is released.

Test Plan:
- Reset mid-stream: with WIDTH=8 and STAGES=2, drive 3 beats, then pulse rst_n low between edges -> out_valid, z and count go to 0 at once, without an edge; no stale beat appears after release.
- All ops, no stall: a=8'hC5, b=8'h3A, op=0..7 back-to-back with out_ready=1 -> z sequence 3A, C5, 00, FF, FF, FF, 00, 00; first out_valid 2 cycles after first accept; then one result per cycle; count=8.
- Back-pressure: stream 6 beats with op=0 and a=1..6 while out_ready=0 -> exactly 2 accepts; in_ready=0 afterwards; z=8'hFE held. Raise out_ready -> outputs FE, FD, FC, FB, FA, F9 in order; count=6.
- Random handshake: 1000 beats, in_valid and out_ready each random at 50% -> output stream equals the reference model in order; count=1000 mod 65536; no stable-hold violation while stalled.
- Counter wrap: CNT_W=3, deliver 9 beats -> count runs 1..7, 0, 1.
- Latency scaling: STAGES=1 and STAGES=4, single isolated beat -> out_valid appears in the cycle after edge N+0 and edge N+3 respectively; in_ready stays 1 throughout.
